sm_reel_engine: RTL and testbench
=================================

// Module: sm_reel_engine
// PURPOSE
//  Parametrised slot-machine reel engine, the successor to the fixed-3-reel sm_engine.
//  Supports N reels, configurable symbol count, spin timing and a staggered reel stop.
//  Adds an early-stop input, optional pseudo-random spin extension and registered win detection.
//  Drives the VGA reel renderer; lever and stop come from debounced board buttons.
// PARAMETERS
//  NUM_REELS   3      number of reels (1..8)
//  NUM_SYMS    8      symbols per reel (2..2**SYM_W)
//  SYM_W       3      bits per symbol index
//  STEP_DIV    4      clock cycles per one-symbol reel advance (>=1)
//  SPIN_CYCLES 100    base length of SPIN phase in cycles (>=1)
//  STOP_GAP    20     cycles between successive reel stops (>=1)
//  EXTRA_W     0      LFSR bits added to SPIN length (0 = deterministic)
//  LFSR_SEED   16'hACE1  non-zero LFSR reset value
// PORTS
//  clk       in   1                 system clock, 100 MHz
//  rst_n     in   1                 asynchronous active-low reset
//  lever     in   1                 spin request; rising edge only
//  stop_req  in   1                 early stop; level, sampled each cycle
//  reel_sym  out  NUM_REELS*SYM_W   reel k symbol at [k*SYM_W +: SYM_W]
//  spinning  out  NUM_REELS         bit k high while reel k advances
//  busy      out  1                 high in SPIN, STOPPING or RESULT
//  done      out  1                 1-cycle pulse in RESULT
//  win       out  1                 all reels equal; registered
// BEHAVIOUR
//  Reset values: reel k = k mod NUM_SYMS; spinning=0; busy=0; done=0; win=0; FSM=IDLE; LFSR=LFSR_SEED.
//  The LFSR (16-bit Galois) steps every cycle, including IDLE.
//  FSM states: IDLE -> SPIN -> STOPPING -> RESULT -> IDLE.
//  IDLE: a lever rising edge (lever=1, lever_q=0) moves the FSM to SPIN on the next cycle.
//    - On SPIN entry: spinning=all ones; win cleared; step and phase counters cleared.
//    - Spin length L = SPIN_CYCLES + LFSR[EXTRA_W-1:0], sampled at SPIN entry.
//  Lever edges in any other state are dropped, never queued. Holding lever high yields one spin.
//  SPIN: ends after L cycles, or on the first cycle stop_req=1. Let E = SPIN cycles elapsed.
//  STOPPING: reel k clears spinning[k] after (k+1)*STOP_GAP cycles in STOPPING.
//    - Reels stop in ascending index order. Last stop -> RESULT.
//    - stop_req is ignored outside SPIN.
//  Advance rule (normative): per spin, reel k advances exactly floor((E+(k+1)*STOP_GAP)/STEP_DIV) times.
//    - The step counter runs continuously across SPIN and STOPPING.
//    - Each advance is +1, wrapping NUM_SYMS-1 -> 0.
//  RESULT: lasts 1 cycle. done=1 and busy stays 1; win <= (all reel_sym equal).
//    - reel_sym and win hold until the next accepted lever edge.
//  Outputs are registered. The first symbol change is visible STEP_DIV cycles after SPIN entry.
//  rst_n low at any time, including mid-spin, aborts asynchronously to reset values.
//  NUM_REELS=1: win=1 at every RESULT.
// STRUCTURE
//  Package sm_pkg: FSM state encodings (IDLE/SPIN/STOPPING/RESULT), LFSR width and tap constant.
//  Sub-module sm_lfsr: 16-bit Galois LFSR with enable, async reset to seed. Instantiated once.
//  EXTRA_W=0 removes the LFSR term via generate.
// TESTING  (defaults unless stated; EXTRA_W=0)
//  1. Reset, lever pulse:
//     - Final reel_sym = {6,4,2} (reels 0,1,2); win=0.
//     - done high exactly 1 cycle; busy low the next cycle.
//  2. Second lever pulse from that state: final reel_sym = {4,7,2}; win=0.
//  3. STOP_GAP=28, fresh reset, lever pulse:
//     - Advances 32/39/46 -> reel_sym={0,0,0}; win=1 at RESULT.
//  4. stop_req held high from SPIN cycle 40:
//     - E=40, advances 15/20/25 -> reel_sym={7,5,3}.
//     - spinning bits clear 20/40/60 cycles later.
//  5. Lever held high 500 cycles, plus extra pulses while busy:
//     - Exactly one spin occurs; busy never glitches.
//  6. rst_n low mid-STOPPING:
//     - All outputs return to reset values immediately.
//     - The next lever pulse reproduces scenario 1.

Source files
------------

// File: rtl/sm_pkg.sv
// Shared definitions for the slot-machine reel engine: FSM states and LFSR constants.
package sm_pkg;

    localparam int unsigned LFSR_W = 16;
    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        StIdle,
        StSpin,
        StStopping,
        StResult
    } sm_state_e;

endpackage

// File: rtl/sm_lfsr.sv
// 16-bit Galois LFSR with step enable and asynchronous reset to a non-zero seed.
module sm_lfsr
    import sm_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/sm_reel_engine.sv
// N-reel slot-machine engine: lever-started spin, optional early stop, staggered reel stops,
// registered win detection at the end of every spin.
module sm_reel_engine
    import sm_pkg::*;
#(
    parameter int unsigned       NUM_REELS   = 3,
    parameter int unsigned       NUM_SYMS    = 8,
    parameter int unsigned       SYM_W       = 3,
    parameter int unsigned       STEP_DIV    = 4,
    parameter int unsigned       SPIN_CYCLES = 100,
    parameter int unsigned       STOP_GAP    = 20,
    parameter int unsigned       EXTRA_W     = 0,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       lever,
    input  logic                       stop_req,
    output logic [NUM_REELS*SYM_W-1:0] reel_sym,
    output logic [NUM_REELS-1:0]       spinning,
    output logic                       busy,
    output logic                       done,
    output logic                       win
);

    localparam int unsigned MaxSpin = SPIN_CYCLES + (1 << EXTRA_W);
    localparam int unsigned MaxStop = NUM_REELS * STOP_GAP;
    localparam int unsigned MaxCnt  = (MaxSpin > MaxStop) ? MaxSpin : MaxStop;
    localparam int unsigned CntW    = $clog2(MaxCnt + 1);
    localparam int unsigned StW     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    sm_state_e            state_q, state_d;
    logic [CntW-1:0]      phase_q, phase_d;
    logic [CntW-1:0]      len_q, len_d;
    logic [StW-1:0]       step_q, step_d;
    logic [NUM_REELS-1:0] spin_q, spin_d;
    logic [SYM_W-1:0]     reel_q [NUM_REELS];
    logic [SYM_W-1:0]     reel_d [NUM_REELS];
    logic                 lever_q;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 win_q, win_d;
    logic                 adv;
    logic                 all_eq;

    logic [LFSR_W-1:0] lfsr_state;
    logic [CntW-1:0]   extra;
    logic              unused_lfsr;

    sm_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (1'b1),
        .state_o(lfsr_state)
    );

    assign unused_lfsr = ^lfsr_state;

    generate
        if (EXTRA_W > 0) begin : g_extra
            assign extra = CntW'(lfsr_state[EXTRA_W-1:0]);
        end else begin : g_no_extra
            assign extra = '0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        len_d   = len_q;
        step_d  = step_q;
        spin_d  = spin_q;
        win_d   = win_q;
        adv     = 1'b0;
        all_eq  = 1'b1;
        for (int k = 0; k < NUM_REELS; k++) begin
            reel_d[k] = reel_q[k];
        end

        // Step counter is shared by SPIN and STOPPING so the advance cadence never restarts.
        if (state_q == StSpin || state_q == StStopping) begin
            adv    = (step_q == StW'(STEP_DIV - 1));
            step_d = adv ? '0 : step_q + StW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (lever && !lever_q) begin
                    state_d = StSpin;
                    spin_d  = '1;
                    win_d   = 1'b0;
                    phase_d = '0;
                    step_d  = '0;
                    len_d   = CntW'(SPIN_CYCLES) + extra;
                end
            end
            StSpin: begin
                if (stop_req || phase_q == len_q - CntW'(1)) begin
                    state_d = StStopping;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + CntW'(1);
                end
            end
            StStopping: begin
                for (int k = 0; k < NUM_REELS; k++) begin
                    if (phase_q == CntW'((k + 1) * STOP_GAP - 1)) begin
                        spin_d[k] = 1'b0;
                    end
                end
                if (phase_q == CntW'(NUM_REELS * STOP_GAP - 1)) begin
                    state_d = StResult;
                end else begin
                    phase_d = phase_q + CntW'(1);
                end
            end
            StResult: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A reel still advances on the very cycle its spinning bit drops.
        for (int k = 0; k < NUM_REELS; k++) begin
            if (adv && spin_q[k]) begin
                reel_d[k] = (reel_q[k] == SYM_W'(NUM_SYMS - 1)) ? '0 : reel_q[k] + SYM_W'(1);
            end
        end

        for (int k = 1; k < NUM_REELS; k++) begin
            if (reel_d[k] != reel_d[0]) begin
                all_eq = 1'b0;
            end
        end
        if (state_d == StResult) begin
            win_d = all_eq;
        end

        busy_d = (state_d != StIdle);
        done_d = (state_d == StResult);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            phase_q <= '0;
            len_q   <= '0;
            step_q  <= '0;
            spin_q  <= '0;
            lever_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            win_q   <= 1'b0;
            for (int k = 0; k < NUM_REELS; k++) begin
                reel_q[k] <= SYM_W'(k % NUM_SYMS);
            end
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            len_q   <= len_d;
            step_q  <= step_d;
            spin_q  <= spin_d;
            lever_q <= lever;
            busy_q  <= busy_d;
            done_q  <= done_d;
            win_q   <= win_d;
            for (int k = 0; k < NUM_REELS; k++) begin
                reel_q[k] <= reel_d[k];
            end
        end
    end

    always_comb begin
        reel_sym = '0;
        for (int k = 0; k < NUM_REELS; k++) begin
            reel_sym[k*SYM_W +: SYM_W] = reel_q[k];
        end
    end

    assign spinning = spin_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign win      = win_q;

endmodule

// File: tb/tb_sm_reel_engine.sv
// Self-checking bench for sm_reel_engine: directed scenarios plus randomized early stops,
// checked cycle by cycle against an arithmetic model of the advance rule.
module tb_sm_reel_engine;

    localparam int NR   = 3;
    localparam int NS   = 8;
    localparam int DIV  = 4;
    localparam int SPIN = 100;
    localparam int GAP  = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          lever, stop_req;
    logic [8:0]    reel_sym;
    logic [2:0]    spinning;
    logic          busy, done, win;
    logic          lever_b;
    logic [8:0]    reel_b;
    logic [2:0]    spin_b;
    logic          busy_b, done_b, win_b;

    int n_cmp = 0;
    int n_bad = 0;
    int sym_m [NR];

    always #5 clk = ~clk;

    sm_reel_engine u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .lever   (lever),
        .stop_req(stop_req),
        .reel_sym(reel_sym),
        .spinning(spinning),
        .busy    (busy),
        .done    (done),
        .win     (win)
    );

    sm_reel_engine #(
        .STOP_GAP(28)
    ) u_dut_g28 (
        .clk     (clk),
        .rst_n   (rst_n),
        .lever   (lever_b),
        .stop_req(1'b0),
        .reel_sym(reel_b),
        .spinning(spin_b),
        .busy    (busy_b),
        .done    (done_b),
        .win     (win_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_reel"}, reel_sym, 9'd136);
        check_eq({tag, "_spin"}, spinning, 3'b000);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_done"}, done, 1'b0);
        check_eq({tag, "_win"}, win, 1'b0);
    endtask

    task automatic do_reset();
        lever    = 1'b0;
        stop_req = 1'b0;
        rst_n    = 1'b0;
        #2;
        check_reset_outputs("async_rst");
        for (int k = 0; k < NR; k++) sym_m[k] = k;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One spin on u_dut. stop_at: SPIN cycle (1-based) where stop_req goes high, 0 = never.
    // abort_at: cycle after entry at which reset is forced (0 = never).
    task automatic run_spin(input int stop_at, input bit hold, input int abort_at);
        int         e, last, stop_n;
        logic [8:0] exp_sym;
        logic [2:0] exp_spin;
        bit         eq;
        e    = (stop_at != 0 && stop_at < SPIN) ? stop_at : SPIN;
        last = e + NR * GAP;
        @(posedge clk); #1;
        lever    = 1'b1;
        stop_req = 1'b0;
        @(posedge clk); #1;
        check_eq("entry_busy", busy, 1'b1);
        check_eq("entry_spin", spinning, 3'b111);
        check_eq("entry_win", win, 1'b0);
        for (int n = 1; n <= last + 3; n++) begin
            lever = hold ? 1'b1 : ((n < last - 2) ? 1'($urandom_range(0, 1)) : 1'b0);
            if (n <= e) stop_req = (stop_at != 0 && n >= stop_at);
            else        stop_req = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (abort_at != 0 && n == abort_at) begin
                do_reset();
                return;
            end
            exp_sym = '0;
            for (int k = 0; k < NR; k++) begin
                stop_n = e + (k + 1) * GAP;
                exp_sym[k*3 +: 3] = 3'((sym_m[k] + ((n < stop_n) ? n : stop_n) / DIV) % NS);
                exp_spin[k] = (n < stop_n);
            end
            eq = (exp_sym[2:0] == exp_sym[5:3]) && (exp_sym[5:3] == exp_sym[8:6]);
            check_eq("reel", reel_sym, exp_sym);
            check_eq("spinning", spinning, exp_spin);
            check_eq("busy", busy, n <= last);
            check_eq("done", done, n == last);
            check_eq("win", win, (n >= last) ? eq : 1'b0);
        end
        for (int k = 0; k < NR; k++) sym_m[k] = (sym_m[k] + (e + (k + 1) * GAP) / DIV) % NS;
        stop_req = 1'b0;
    endtask

    initial begin
        int seen;
        rst_n    = 1'b0;
        lever    = 1'b0;
        stop_req = 1'b0;
        lever_b  = 1'b0;
        for (int k = 0; k < NR; k++) sym_m[k] = k;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check_eq("reset_b_reel", reel_b, 9'd136);
        @(negedge clk);
        rst_n = 1'b1;

        // STOP_GAP=28 instance: all reels land on 0 and win.
        @(posedge clk); #1;
        lever_b = 1'b1;
        @(posedge clk); #1;
        lever_b = 1'b0;
        seen = 0;
        for (int n = 1; n <= 400 && seen == 0; n++) begin
            @(posedge clk); #1;
            if (done_b) seen = n;
        end
        check_eq("g28_done_cycle", seen, 100 + 3 * 28);
        check_eq("g28_reel", reel_b, 9'd0);
        check_eq("g28_win", win_b, 1'b1);
        @(posedge clk); #1;
        check_eq("g28_busy_after", busy_b, 1'b0);
        check_eq("g28_done_after", done_b, 1'b0);

        run_spin(0, 1'b0, 0);
        check_eq("t1_reel", reel_sym, 9'd166);
        check_eq("t1_win", win, 1'b0);
        run_spin(0, 1'b0, 0);
        check_eq("t2_reel", reel_sym, 9'd188);

        // Abort mid-STOPPING, then the next spin must reproduce the first one.
        run_spin(0, 1'b0, SPIN + 30);
        check_reset_outputs("abort_after");
        run_spin(0, 1'b0, 0);
        check_eq("t6_reel", reel_sym, 9'd166);

        do_reset();
        run_spin(40, 1'b0, 0);
        check_eq("t4_reel", reel_sym, 9'd239);

        // Lever held high: one spin only, busy stays low afterwards.
        run_spin(0, 1'b1, 0);
        for (int n = 0; n < 330; n++) begin
            @(posedge clk); #1;
            check_eq("hold_busy", busy, 1'b0);
        end
        lever = 1'b0;

        run_spin(1, 1'b0, 0);
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            run_spin(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 110)), 1'b0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
